// File: rtl/depth_stream_packer_fp16.sv
`default_nettype none
// ============================================================================
// Module      : depth_stream_packer_fp16
// Description : Output sink for the fp16 depth pipeline. Gates depth by a
//               confidence threshold, checks raster order and buffers beats
//               in a FIFO. The FIFO drives a ready/valid stream that carries
//               start-of-frame and end-of-line markers.
// Revision    : 1.0 - initial release
// ============================================================================
module depth_stream_packer_fp16 #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  // Image geometry has no meaningful default and must be overridden.
  parameter int IMAGE_WIDTH  = 0,
  parameter int IMAGE_HEIGHT = 0,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FP_WIDTH_REG-1:0]   z_i,
  input  logic [FP_WIDTH_REG-1:0]   c_i,
  input  logic [15:0]               col_i,
  input  logic [15:0]               row_i,
  input  logic                      valid_i,
  input  logic [FP_WIDTH_REG-1:0]   c_thresh_i,
  input  logic                      clear_i,
  output logic [2*FP_WIDTH_REG-1:0] m_data_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic                      m_sof_o,
  output logic                      m_eol_o,
  output logic                      overflow_o,
  output logic                      order_err_o,
  output logic [15:0]               frame_count_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam int ENTRY_W = 2 * FP_WIDTH_REG + 2;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]      LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  // Raster successor of a coordinate, packed as {row, col}; wraps at frame end.
  function automatic logic [31:0] raster_succ(input logic [15:0] col,
                                              input logic [15:0] row);
    logic [15:0] nc;
    logic [15:0] nr;
    if (col >= LAST_COL) begin
      nc = 16'd0;
      nr = (row >= LAST_ROW) ? 16'd0 : row + 16'd1;
    end else begin
      nc = col + 16'd1;
      nr = row;
    end
    return {nr, nc};
  endfunction

  // --------------------------------------------------------------------------
  // Confidence gating and FIFO entry formation
  // --------------------------------------------------------------------------
  logic                    c_sign;
  logic                    c_nan;
  logic                    c_pass;
  logic [FP_WIDTH_REG-1:0] z_gated;
  logic                    beat_sof;
  logic                    beat_eol;
  logic [ENTRY_W-1:0]      wr_entry_d;

  // Raw-bit unsigned compare is ordered for non-negative non-NaN values only,
  // so negative and NaN confidences are rejected outright.
  always_comb begin
    c_sign     = c_i[FP_WIDTH_REG-1];
    c_nan      = (&c_i[FP_WIDTH_REG-2 -: EXP_WIDTH]) && (|c_i[FRAC_WIDTH-1:0]);
    c_pass     = !c_sign && !c_nan && (c_i >= c_thresh_i);
    z_gated    = c_pass ? z_i : '0;
    beat_sof   = (col_i == 16'd0) && (row_i == 16'd0);
    beat_eol   = (col_i == LAST_COL);
    wr_entry_d = {z_gated, c_i, beat_sof, beat_eol};
  end

  // --------------------------------------------------------------------------
  // FIFO: the head entry is presented directly, so an empty FIFO gives
  // one-cycle latency and a full FIFO can accept a write while it pops.
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Push/pop decisions and pointer/occupancy next state.
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = m_valid_o && m_ready_i;
    push     = valid_i && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are never observed while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  // Output stream: the head entry is forced to zero while the FIFO is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    m_valid_o = (count_q != '0);
    m_data_o  = m_valid_o ? head[ENTRY_W-1:2] : '0;
    m_sof_o   = m_valid_o && head[1];
    m_eol_o   = m_valid_o && head[0];
  end

  // --------------------------------------------------------------------------
  // Raster order checker and sticky status
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] exp_col_q, exp_col_d;
  logic [15:0] exp_row_q, exp_row_d;
  logic        frame_err_q, frame_err_d;
  logic        order_err_q, order_err_d;
  logic        overflow_q, overflow_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        at_origin;
  logic        at_expected;
  logic        at_last;
  logic        order_set;
  logic        frame_done;

  // Checker next state; it observes every offered beat, dropped or not.
  always_comb begin
    state_d     = state_q;
    exp_col_d   = exp_col_q;
    exp_row_d   = exp_row_q;
    frame_err_d = frame_err_q;
    order_set   = 1'b0;
    frame_done  = 1'b0;
    at_origin   = (col_i == 16'd0) && (row_i == 16'd0);
    at_expected = (col_i == exp_col_q) && (row_i == exp_row_q);
    at_last     = (col_i == LAST_COL) && (row_i == LAST_ROW);
    if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (at_origin) begin
            state_d                = ST_IN_FRAME;
            {exp_row_d, exp_col_d} = raster_succ(16'd0, 16'd0);
            frame_err_d            = 1'b0;
          end else begin
            order_set = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          if (at_expected) begin
            if (at_last) begin
              state_d    = ST_IDLE;
              frame_done = !frame_err_q;
            end else begin
              {exp_row_d, exp_col_d} = raster_succ(col_i, row_i);
            end
          end else if (at_origin) begin
            // Premature frame start: restart tracking, but the frame that
            // begins with the error is never counted.
            order_set              = 1'b1;
            frame_err_d            = 1'b1;
            {exp_row_d, exp_col_d} = raster_succ(16'd0, 16'd0);
          end else begin
            order_set              = 1'b1;
            frame_err_d            = 1'b1;
            {exp_row_d, exp_col_d} = raster_succ(col_i, row_i);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky flags and frame counter; a same-cycle set beats clear.
  always_comb begin
    overflow_d    = (valid_i && !push) ? 1'b1 : (clear_i ? 1'b0 : overflow_q);
    order_err_d   = order_set ? 1'b1 : (clear_i ? 1'b0 : order_err_q);
    frame_count_d = (clear_i ? 16'd0 : frame_count_q) + {15'd0, frame_done};
  end

  assign overflow_o    = overflow_q;
  assign order_err_o   = order_err_q;
  assign frame_count_o = frame_count_q;

  // State registers for FIFO control, checker and status.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      exp_col_q     <= '0;
      exp_row_q     <= '0;
      frame_err_q   <= 1'b0;
      order_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      exp_col_q     <= exp_col_d;
      exp_row_q     <= exp_row_d;
      frame_err_q   <= frame_err_d;
      order_err_q   <= order_err_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_depth_stream_packer_fp16.sv
`default_nettype none
// ============================================================================
// Module      : tb_depth_stream_packer_fp16
// Description : Directed, table-driven bench for depth_stream_packer_fp16
//               with a 4x2 image and a 4-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depth_stream_packer_fp16;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] z_i;
  logic [15:0] c_i;
  logic [15:0] col_i;
  logic [15:0] row_i;
  logic        valid_i;
  logic [15:0] c_thresh_i;
  logic        clear_i;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_sof_o;
  logic        m_eol_o;
  logic        overflow_o;
  logic        order_err_o;
  logic [15:0] frame_count_o;

  depth_stream_packer_fp16 #(
    .EXP_WIDTH   (5),
    .FRAC_WIDTH  (10),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .z_i          (z_i),
    .c_i          (c_i),
    .col_i        (col_i),
    .row_i        (row_i),
    .valid_i      (valid_i),
    .c_thresh_i   (c_thresh_i),
    .clear_i      (clear_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_sof_o      (m_sof_o),
    .m_eol_o      (m_eol_o),
    .overflow_o   (overflow_o),
    .order_err_o  (order_err_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] z;
    logic [15:0] c;
    logic [31:0] exp_data;
    logic        exp_sof;
    logic        exp_eol;
  } vec_t;

  vec_t        vecs [16];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] zz;
  logic [31:0] expd;
  logic [31:0] sb [$];
  int          oc [7];
  int          orow [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [15:0] col, input logic [15:0] row,
                       input logic [15:0] z, input logic [15:0] c);
    col_i   = col;
    row_i   = row;
    z_i     = z;
    c_i     = c;
    valid_i = 1'b1;
  endtask

  task automatic pulse_clear();
    valid_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // One clean 4x2 frame with ready held high; each beat is checked one cycle later.
  task automatic run_clean_frame(input string tag);
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(16'(i % 4), 16'(i / 4), 16'h4000, 16'h3C00);
      tick();
      chk({tag, "_valid"}, {31'd0, m_valid_o}, 32'd1);
      chk({tag, "_data"}, m_data_o, 32'h4000_3C00);
      chk({tag, "_sof"}, {31'd0, m_sof_o}, (i == 0) ? 32'd1 : 32'd0);
      chk({tag, "_eol"}, {31'd0, m_eol_o}, (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    // Frame 1: clean; frame 2: gating corner cases (NaN, negative, +Inf, edges).
    vecs[0]  = '{16'd0, 16'd0, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b1, 1'b0};
    vecs[1]  = '{16'd1, 16'd0, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b0};
    vecs[2]  = '{16'd2, 16'd0, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b0};
    vecs[3]  = '{16'd3, 16'd0, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b1};
    vecs[4]  = '{16'd0, 16'd1, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b0};
    vecs[5]  = '{16'd1, 16'd1, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b0};
    vecs[6]  = '{16'd2, 16'd1, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b0};
    vecs[7]  = '{16'd3, 16'd1, 16'h4000, 16'h3C00, 32'h4000_3C00, 1'b0, 1'b1};
    vecs[8]  = '{16'd0, 16'd0, 16'h4000, 16'h3400, 32'h0000_3400, 1'b1, 1'b0};
    vecs[9]  = '{16'd1, 16'd0, 16'h4000, 16'hBC00, 32'h0000_BC00, 1'b0, 1'b0};
    vecs[10] = '{16'd2, 16'd0, 16'h4000, 16'h7E00, 32'h0000_7E00, 1'b0, 1'b0};
    vecs[11] = '{16'd3, 16'd0, 16'h4000, 16'h3800, 32'h4000_3800, 1'b0, 1'b1};
    vecs[12] = '{16'd0, 16'd1, 16'h4000, 16'h7C00, 32'h4000_7C00, 1'b0, 1'b0};
    vecs[13] = '{16'd1, 16'd1, 16'h4000, 16'h3801, 32'h4000_3801, 1'b0, 1'b0};
    vecs[14] = '{16'd2, 16'd1, 16'h4000, 16'h37FF, 32'h0000_37FF, 1'b0, 1'b0};
    vecs[15] = '{16'd3, 16'd1, 16'h4000, 16'hFC00, 32'h0000_FC00, 1'b0, 1'b1};
    oc   = '{0, 1, 3, 0, 1, 2, 3};
    orow = '{0, 0, 0, 1, 1, 1, 1};

    rst_i      = 1'b0;
    valid_i    = 1'b0;
    z_i        = '0;
    c_i        = '0;
    col_i      = '0;
    row_i      = '0;
    c_thresh_i = 16'h3800;
    clear_i    = 1'b0;
    m_ready_i  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_data", m_data_o, 32'd0);
    chk("rst_sof_eol", {30'd0, m_sof_o, m_eol_o}, 32'd0);
    chk("rst_flags", {30'd0, overflow_o, order_err_o}, 32'd0);
    chk("rst_fcount", {16'd0, frame_count_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Table: clean frame then gating frame, ready held high
    m_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].col, vecs[i].row, vecs[i].z, vecs[i].c);
      tick();
      chk("tbl_valid", {31'd0, m_valid_o}, 32'd1);
      chk("tbl_data", m_data_o, vecs[i].exp_data);
      chk("tbl_sof", {31'd0, m_sof_o}, {31'd0, vecs[i].exp_sof});
      chk("tbl_eol", {31'd0, m_eol_o}, {31'd0, vecs[i].exp_eol});
    end
    valid_i = 1'b0;
    tick();
    chk("tbl_empty", {31'd0, m_valid_o}, 32'd0);
    chk("tbl_fcount", {16'd0, frame_count_o}, 32'd2);
    chk("tbl_flags", {30'd0, overflow_o, order_err_o}, 32'd0);

    // Overflow: full frame offered with ready low
    pulse_clear();
    chk("clr_fcount", {16'd0, frame_count_o}, 32'd0);
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      zz = 16'h1000 + 16'(i);
      drive(16'(i % 4), 16'(i / 4), zz, 16'h3C00);
      tick();
      chk("ovf_flag", {31'd0, overflow_o}, (i >= 4) ? 32'd1 : 32'd0);
    end
    valid_i   = 1'b0;
    m_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      zz = 16'h1000 + 16'(k);
      chk("ovf_drain_valid", {31'd0, m_valid_o}, 32'd1);
      chk("ovf_drain_data", m_data_o, {zz, 16'h3C00});
      tick();
    end
    chk("ovf_drained", {31'd0, m_valid_o}, 32'd0);
    chk("ovf_fcount", {16'd0, frame_count_o}, 32'd1);
    chk("ovf_order", {31'd0, order_err_o}, 32'd0);

    // Full plus pop: fill 4, then 12 beats with simultaneous pop
    pulse_clear();
    chk("fp_ovf_clr", {31'd0, overflow_o}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      m_ready_i = (i >= 4);
      if (i >= 4) begin
        expd = sb.pop_front();
        chk("fp_data", m_data_o, expd);
      end
      zz = 16'h2000 + 16'(i);
      drive(16'(i % 4), 16'((i / 4) % 2), zz, 16'h3C00);
      sb.push_back({zz, 16'h3C00});
      tick();
      chk("fp_ovf", {31'd0, overflow_o}, 32'd0);
    end
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expd = sb.pop_front();
      chk("fp_drain_valid", {31'd0, m_valid_o}, 32'd1);
      chk("fp_drain_data", m_data_o, expd);
      tick();
    end
    chk("fp_empty", {31'd0, m_valid_o}, 32'd0);
    chk("fp_fcount", {16'd0, frame_count_o}, 32'd2);
    chk("fp_order", {31'd0, order_err_o}, 32'd0);

    // Order error: (0,0),(1,0),(3,0),(0,1)...(3,1)
    pulse_clear();
    m_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      zz = 16'h3000 + 16'(i);
      drive(16'(oc[i]), 16'(orow[i]), zz, 16'h3C00);
      tick();
      chk("oe_data", m_data_o, {zz, 16'h3C00});
      chk("oe_flag", {31'd0, order_err_o}, (i >= 2) ? 32'd1 : 32'd0);
    end
    valid_i = 1'b0;
    tick();
    chk("oe_fcount", {16'd0, frame_count_o}, 32'd0);
    chk("oe_empty", {31'd0, m_valid_o}, 32'd0);
    pulse_clear();
    chk("oe_clr", {31'd0, order_err_o}, 32'd0);
    run_clean_frame("oe_clean");
    tick();
    chk("oe_clean_fcount", {16'd0, frame_count_o}, 32'd1);
    chk("oe_clean_flags", {30'd0, overflow_o, order_err_o}, 32'd0);

    // Reset mid-frame with buffered beats
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'(i), 16'd0, 16'h4000, 16'h3C00);
      tick();
    end
    valid_i = 1'b0;
    chk("mr_pre_valid", {31'd0, m_valid_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mr_valid", {31'd0, m_valid_o}, 32'd0);
    chk("mr_data", m_data_o, 32'd0);
    chk("mr_fcount", {16'd0, frame_count_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    run_clean_frame("mr_clean");
    tick();
    chk("mr_clean_empty", {31'd0, m_valid_o}, 32'd0);
    chk("mr_clean_fcount", {16'd0, frame_count_o}, 32'd1);
    chk("mr_clean_flags", {30'd0, overflow_o, order_err_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/depth_stream_packer_fp16.md
# depth_stream_packer_fp16

Output-side sink for the fp16 dual-scale depth pipeline. It takes the free-running, non-stallable depth (z) and confidence (c) pixel stream, gates z by a confidence threshold, and checks raster order. It buffers beats in a FIFO and presents them on a ready/valid stream with start-of-frame and end-of-line markers for a DMA or host link. Overflow and ordering faults are reported as sticky flags, because the upstream pipeline has no backpressure.

## Interface

Parameters:
- EXP_WIDTH, 5, fp exponent width
- FRAC_WIDTH, 10, fp fraction width
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, fp word width (local)
- IMAGE_WIDTH, none (must be set), pixels per line
- IMAGE_HEIGHT, none (must be set), lines per frame
- FIFO_DEPTH, 64, total beat capacity including the output register; power of 2, ≥4

Ports:
- clk_i  in  1  sole clock
- rst_i  in  1  asynchronous, active-low reset
- z_i  in  FP_WIDTH_REG  depth value
- c_i  in  FP_WIDTH_REG  confidence value
- col_i  in  16  pixel column
- row_i  in  16  pixel row
- valid_i  in  1  beat present; cannot be stalled
- c_thresh_i  in  FP_WIDTH_REG  non-negative fp confidence threshold, quasi-static
- clear_i  in  1  sync pulse; clears the sticky flags and frame_count_o
- m_data_o  out  2*FP_WIDTH_REG  {z_gated, c}
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream accept
- m_sof_o  out  1  beat is (col 0, row 0)
- m_eol_o  out  1  beat has col == IMAGE_WIDTH-1
- overflow_o  out  1  sticky: a beat was dropped because the FIFO was full
- order_err_o  out  1  sticky: raster-order violation
- frame_count_o  out  16  completed clean frames, wraps at 2^16

## Operation

- **Gating.** z_gated = z_i when c_i ≥ c_thresh_i; otherwise z_gated = 0x0000. c always passes through unchanged.
  - The compare is an unsigned compare of the raw bits; this is valid for non-negative, non-NaN values.
  - c_i with sign=1, or c_i that is NaN (exp all ones, frac ≠ 0), is always gated.
  - +Inf compares normally.
- **FIFO entry.** Each entry is {z_gated, c, sof, eol}, computed from col_i/row_i at capture.
- **Write rule.** A beat is written when valid_i=1 and either occupancy < FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the beat is dropped and overflow_o is set.
- **Pop.** A pop occurs when m_valid_o & m_ready_i.
- **Output hold.** While m_valid_o=1 and m_ready_i=0, m_data_o, m_sof_o and m_eol_o hold stable.
- **Order checker FSM.** It sees every valid_i beat, including dropped ones. It keeps exp_col/exp_row.
  - **IDLE.** A beat at (0,0) moves to IN_FRAME with expected (1,0). Any other beat sets order_err_o and the FSM stays in IDLE.
  - **IN_FRAME, beat == expected.** Advance the expectation in raster order: col wraps at IMAGE_WIDTH-1, row increments.
  - **IN_FRAME, last pixel.** A matching beat at (W-1,H-1) moves to IDLE. frame_count_o increments only if no order error occurred in that frame.
  - **IN_FRAME, mismatch at (0,0).** Set order_err_o and restart the frame: stay in IN_FRAME, expected (1,0), frame not counted.
  - **IN_FRAME, other mismatch.** Set order_err_o and resync the expectation to the successor of the received coordinate.
- **Checker and data path are independent.** All beats are written (subject only to capacity) regardless of order errors.
- **clear_i.** Clears overflow_o, order_err_o and frame_count_o. If an error sets in the same cycle, the set wins. clear_i does not flush the FIFO or change the FSM.

## Timing

- **Reset (rst_i=0, asynchronous).**
  - All outputs go to 0, including m_data_o.
  - The FIFO empties and the FSM returns to IDLE.
  - Reset applied mid-frame discards all buffered beats.
- **Latency.** A beat captured at edge N is visible on m_* after edge N when the FIFO was empty (1 cycle). Otherwise it appears in order behind earlier beats.
- **Throughput.** One write and one pop per cycle, sustained.
- **Flag and counter timing.** overflow_o and order_err_o assert after the edge at which the offending beat is sampled. frame_count_o updates after the edge that samples the last pixel.
- **Full with simultaneous pop.** When occupancy == FIFO_DEPTH and a pop coincides with valid_i, the write succeeds, occupancy stays at FIFO_DEPTH, and no overflow is flagged.
- **Pointer wrap.** Pointers wrap modulo FIFO_DEPTH; the bench must exercise at least 3×FIFO_DEPTH beats.

## Test plan

All scenarios use IMAGE_WIDTH=4, IMAGE_HEIGHT=2, FIFO_DEPTH=4.

- **Clean frame.** Stimulus: 8 raster beats, z=0x4000, c=0x3C00, thresh=0x3800, m_ready_i=1. Required: 8 beats, each 1 cycle after input, m_data_o=0x40003C00. m_sof_o on beat 1 only, m_eol_o on beats 4 and 8. frame_count_o=1, both flags 0.
- **Gating.** Stimulus: c = 0x3400, 0xBC00, 0x7E00, 0x3800 with thresh=0x3800 and z=0x4000. Required: z out = 0x0000, 0x0000, 0x0000, 0x4000.
- **Overflow.** Stimulus: m_ready_i=0 for a full 8-beat frame. Required: overflow_o=1 after the 5th beat. Then with m_ready_i=1, exactly (0,0),(1,0),(2,0),(3,0) drain. frame_count_o=1, order_err_o=0.
- **Full plus pop.** Stimulus: fill to 4 entries, then hold valid_i=1 and m_ready_i=1 for 12 beats. Required: no overflow, and output order equals input order.
- **Order error.** Stimulus: (0,0),(1,0),(3,0),(0,1)… Required: order_err_o=1 after the 3rd beat, all beats emitted, frame_count_o unchanged. Then clear_i clears order_err_o, and a following clean frame gives frame_count_o=1.
- **Reset mid-frame.** Stimulus: drive rst_i=0 after 3 beats with m_ready_i=0. Required: m_valid_o=0 immediately. After release, a clean frame gives 8 beats, frame_count_o=1 and no flags.
